// File: rtl/pipe_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_addsub : pipelined add/sub, carry chain split into STAGES chunks     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c,
  output logic             ovf,
  output logic             zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             advance;
  logic             valid_q [STAGES];
  logic             carry_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] bx_q    [STAGES];
  logic [WIDTH-1:0] res_q   [STAGES];

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic             ovf_q;
  logic             zero_q;

  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  // The whole pipeline freezes on a stall; bubbles are never collapsed.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             valid_in;
    logic             carry_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] bx_in;
    logic [WIDTH-1:0] res_in;
    logic [WIDTH-1:0] res_d;
    logic [CW:0]      chunk_d;

    if (k == 0) begin : g_head
      // Subtraction is a + ~b + 1; the +1 enters as the chunk-0 carry-in.
      assign valid_in = in_valid;
      assign carry_in = sub;
      assign a_in     = a;
      assign bx_in    = b ^ {WIDTH{sub}};
      assign res_in   = '0;
    end else begin : g_body
      assign valid_in = valid_q[k-1];
      assign carry_in = carry_q[k-1];
      assign a_in     = a_q[k-1];
      assign bx_in    = bx_q[k-1];
      assign res_in   = res_q[k-1];
    end

    assign chunk_d = {1'b0, a_in[k*CW +: CW]} + {1'b0, bx_in[k*CW +: CW]}
                   + {{CW{1'b0}}, carry_in};

    always_comb begin
      res_d                = res_in;
      res_d[k*CW +: CW]    = chunk_d[CW-1:0];
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q[k] <= 1'b0;
      end else if (advance) begin
        valid_q[k] <= valid_in;
      end
    end

    always_ff @(posedge clock) begin
      if (advance) begin
        carry_q[k] <= chunk_d[CW];
        a_q[k]     <= a_in;
        bx_q[k]    <= bx_in;
        res_q[k]   <= res_d;
      end
    end
  end

  // Signs of a and the (possibly inverted) b agree for both add and sub overflow.
  assign sum_d = res_q[LAST];
  assign ovf_d = (a_q[LAST][WIDTH-1] == bx_q[LAST][WIDTH-1]) &&
                 (sum_d[WIDTH-1] != a_q[LAST][WIDTH-1]);

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_q         <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      out_valid_q <= valid_q[LAST];
      if (valid_q[LAST]) begin
        sum_q  <= sum_d;
        c_q    <= carry_q[LAST];
        ovf_q  <= ovf_d;
        zero_q <= ~|sum_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c         = c_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire
